// File: rtl/brush_writer.sv
// rtl/brush_writer.sv - expands brush/clear commands into clipped row-major pixel writes
// Optional macro BRUSH_BLANK_GATE_EN: issue writes only while blank=1, stalling the sweep otherwise.
module brush_writer #(
   parameter int         WIDTH    = 640,
   parameter int         HEIGHT   = 480,
   parameter logic [2:0] BG_COLOR = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       brush,
   input  logic       clear,
   input  logic [9:0] cx,
   input  logic [9:0] cy,
   input  logic [1:0] radius,
   input  logic [2:0] newColor,
   input  logic       blank,
   output logic       ready,
   output logic       we,
   output logic [9:0] wx,
   output logic [9:0] wy,
   output logic [2:0] wColor,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

   localparam logic [9:0]        X_MAX   = 10'(WIDTH - 1);
   localparam logic [9:0]        Y_MAX   = 10'(HEIGHT - 1);
   localparam logic signed [10:0] X_MAX_S = 11'(WIDTH - 1);
   localparam logic signed [10:0] Y_MAX_S = 11'(HEIGHT - 1);

   state_t     state, state_n;
   logic       fin, fin_n;
   logic [9:0] px, py, px_n, py_n;
   logic [9:0] xs_q, xe_q, ye_q, xs_n, xe_n, ye_n;
   logic [2:0] col_q, col_n;
   logic       we_n, done_n, ready_n;
   logic [9:0] wx_n, wy_n;
   logic [2:0] wc_n;

   logic              go, gate_ok, off_canvas;
   logic [9:0]        cur_x, cur_y;
   logic signed [10:0] lo_x, hi_x, lo_y, hi_y;
   logic [9:0]        bx_s, bx_e, by_s, by_e;

`ifdef BRUSH_BLANK_GATE_EN
   assign gate_ok = blank;
`else
   logic unused_blank;
   assign unused_blank = blank;
   assign gate_ok      = 1'b1;
`endif

   // Clip the brush square against the canvas in signed arithmetic so cx-r can go negative.
   assign lo_x = $signed({1'b0, cx}) - $signed({9'd0, radius});
   assign hi_x = $signed({1'b0, cx}) + $signed({9'd0, radius});
   assign lo_y = $signed({1'b0, cy}) - $signed({9'd0, radius});
   assign hi_y = $signed({1'b0, cy}) + $signed({9'd0, radius});
   assign bx_s = (lo_x < 11'sd0) ? 10'd0 : lo_x[9:0];
   assign by_s = (lo_y < 11'sd0) ? 10'd0 : lo_y[9:0];
   assign bx_e = (hi_x > X_MAX_S) ? X_MAX : hi_x[9:0];
   assign by_e = (hi_y > Y_MAX_S) ? Y_MAX : hi_y[9:0];
   assign off_canvas = (32'(cx) >= WIDTH) || (32'(cy) >= HEIGHT);

   always_comb begin
      state_n = state;
      fin_n   = fin;
      px_n    = px;
      py_n    = py;
      xs_n    = xs_q;
      xe_n    = xe_q;
      ye_n    = ye_q;
      col_n   = col_q;
      we_n    = 1'b0;
      wx_n    = wx;
      wy_n    = wy;
      wc_n    = wColor;
      done_n  = 1'b0;
      go      = 1'b0;
      cur_x   = px;
      cur_y   = py;
      case (state)
         IDLE: begin
            if (clear) begin
               state_n = CLEAR;
               xs_n    = 10'd0;
               xe_n    = X_MAX;
               ye_n    = Y_MAX;
               col_n   = BG_COLOR;
               fin_n   = 1'b0;
               cur_x   = 10'd0;
               cur_y   = 10'd0;
               go      = 1'b1;
            end else if (brush) begin
               if (off_canvas) begin
                  done_n = 1'b1;
               end else begin
                  state_n = PAINT;
                  xs_n    = bx_s;
                  xe_n    = bx_e;
                  ye_n    = by_e;
                  col_n   = newColor;
                  fin_n   = 1'b0;
                  cur_x   = bx_s;
                  cur_y   = by_s;
                  go      = 1'b1;
               end
            end
         end
         PAINT, CLEAR: begin
            if (fin) begin
               state_n = IDLE;
               fin_n   = 1'b0;
               done_n  = 1'b1;
            end else begin
               go = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // The first pixel is emitted on the accepting edge, so accept and sweep share this path.
      if (go) begin
         if (gate_ok) begin
            we_n = 1'b1;
            wx_n = cur_x;
            wy_n = cur_y;
            wc_n = col_n;
            if (cur_x == xe_n) begin
               px_n  = xs_n;
               py_n  = cur_y + 10'd1;
               fin_n = (cur_y == ye_n);
            end else begin
               px_n = cur_x + 10'd1;
               py_n = cur_y;
            end
         end else begin
            px_n = cur_x;
            py_n = cur_y;
         end
      end
      ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         fin    <= 1'b0;
         px     <= 10'd0;
         py     <= 10'd0;
         xs_q   <= 10'd0;
         xe_q   <= 10'd0;
         ye_q   <= 10'd0;
         col_q  <= 3'd0;
         ready  <= 1'b1;
         we     <= 1'b0;
         wx     <= 10'd0;
         wy     <= 10'd0;
         wColor <= 3'd0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         fin    <= fin_n;
         px     <= px_n;
         py     <= py_n;
         xs_q   <= xs_n;
         xe_q   <= xe_n;
         ye_q   <= ye_n;
         col_q  <= col_n;
         ready  <= ready_n;
         we     <= we_n;
         wx     <= wx_n;
         wy     <= wy_n;
         wColor <= wc_n;
         done   <= done_n;
      end
   end

endmodule

// File: tb/tb_brush_writer.sv
// tb/tb_brush_writer.sv - directed self-checking bench for brush_writer
module tb_brush_writer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, brush, clear, blank, s_brush, s_clear;
   logic [9:0] cx, cy;
   logic [1:0] radius;
   logic [2:0] newColor;
   logic       ready, we, done, s_ready, s_we, s_done;
   logic [9:0] wx, wy, s_wx, s_wy;
   logic [2:0] wColor, s_wColor;

   int   n_cmp = 0;
   int   n_err = 0;
   int   qx[$], qy[$], qc[$];
   logic first_we, ready_mid;
   int   done_i;

   brush_writer u_dut (
      .clk(clk), .reset_n(reset_n), .brush(brush), .clear(clear), .cx(cx), .cy(cy),
      .radius(radius), .newColor(newColor), .blank(blank), .ready(ready), .we(we),
      .wx(wx), .wy(wy), .wColor(wColor), .done(done)
   );

   brush_writer #(.WIDTH(16), .HEIGHT(12), .BG_COLOR(3'b010)) u_small (
      .clk(clk), .reset_n(reset_n), .brush(s_brush), .clear(s_clear), .cx(cx), .cy(cy),
      .radius(radius), .newColor(newColor), .blank(blank), .ready(s_ready), .we(s_we),
      .wx(s_wx), .wy(s_wy), .wColor(s_wColor), .done(s_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives the command for the next edge and records every write until done.
   task automatic cmd(input logic b, input logic c, input logic [9:0] x, input logic [9:0] y,
                      input logic [1:0] r, input logic [2:0] col, input bit glitch);
      brush = b; clear = c; cx = x; cy = y; radius = r; newColor = col;
      qx.delete(); qy.delete(); qc.delete();
      done_i = -1; ready_mid = 1'bx;
      @(negedge clk);
      brush = 1'b0; clear = 1'b0;
      first_we = we;
      for (int i = 0; i < 64; i++) begin
         if (i == 1) ready_mid = ready;
         if (glitch && i == 2) begin brush = 1'b1; cx = 10'd5; newColor = 3'd7; end
         if (glitch && i == 3) brush = 1'b0;
         if (we) begin
            qx.push_back(int'(wx)); qy.push_back(int'(wy)); qc.push_back(int'(wColor));
         end
         if (done) begin done_i = i; break; end
         @(negedge clk);
      end
   endtask

   task automatic check_sweep(input string tag, input int x0, input int x1, input int y0,
                              input int y1, input int col);
      int idx = 0;
      chk({tag, "_count"}, qx.size(), (x1 - x0 + 1) * (y1 - y0 + 1));
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++) begin
            if (idx < qx.size()) begin
               chk($sformatf("%s_x%0d", tag, idx), qx[idx], xx);
               chk($sformatf("%s_y%0d", tag, idx), qy[idx], yy);
               chk($sformatf("%s_c%0d", tag, idx), qc[idx], col);
            end
            idx++;
         end
   endtask

   initial begin
      int cnt, bad, ord, ex, ey, lx, ly, sdone, nw;
      logic smid;
      reset_n = 1'b0; brush = 1'b0; clear = 1'b0; s_brush = 1'b0; s_clear = 1'b0;
      blank = 1'b1; cx = '0; cy = '0; radius = '0; newColor = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1); chk("rst_we", we, 0); chk("rst_wx", wx, 0);
      chk("rst_wy", wy, 0); chk("rst_wcolor", wColor, 0); chk("rst_done", done, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", ready, 1);

      cmd(1, 0, 10'd100, 10'd50, 2'd1, 3'd5, 0);
      chk("centre_first_we", first_we, 1);
      check_sweep("centre", 99, 101, 49, 51, 5);
      chk("centre_done_cycle", done_i, 9);
      chk("centre_busy", ready_mid, 0);
      chk("centre_ready_at_done", ready, 1);

      cmd(1, 0, 10'd0, 10'd0, 2'd3, 3'd1, 0);
      check_sweep("corner_tl", 0, 3, 0, 3, 1);
      cmd(1, 0, 10'd639, 10'd479, 2'd3, 3'd2, 0);
      check_sweep("corner_br", 636, 639, 476, 479, 2);

      cmd(1, 0, 10'd700, 10'd10, 2'd2, 3'd4, 0);
      chk("offx_writes", qx.size(), 0);
      chk("offx_done_cycle", done_i, 0);
      cmd(1, 0, 10'd5, 10'd480, 2'd0, 3'd4, 0);
      chk("offy_writes", qx.size(), 0);
      chk("offy_done_cycle", done_i, 0);

      cmd(1, 0, 10'd200, 10'd100, 2'd1, 3'd3, 1);
      check_sweep("ignore", 199, 201, 99, 101, 3);
      chk("ignore_busy", ready_mid, 0);
      cmd(1, 0, 10'd10, 10'd20, 2'd0, 3'd6, 0);
      chk("b2b_first_we", first_we, 1);
      check_sweep("b2b", 10, 10, 20, 20, 6);
      chk("b2b_done_cycle", done_i, 1);

`ifdef BRUSH_BLANK_GATE_EN
      qx.delete(); qy.delete(); qc.delete();
      bad = 0; sdone = 0;
      brush = 1'b1; cx = 10'd100; cy = 10'd50; radius = 2'd1; newColor = 3'd5;
      for (int k = 0; k < 60; k++) begin
         blank = (k % 3 == 0);
         smid = blank;
         @(negedge clk);
         brush = 1'b0;
         if (we) begin
            qx.push_back(int'(wx)); qy.push_back(int'(wy)); qc.push_back(int'(wColor));
            if (!smid) bad++;
         end
         if (done) begin sdone = 1; break; end
      end
      blank = 1'b1;
      check_sweep("gate", 99, 101, 49, 51, 5);
      chk("gate_blank_only", bad, 0);
      chk("gate_done_seen", sdone, 1);
`endif

      brush = 1'b1; cx = 10'd100; cy = 10'd100; radius = 2'd2; newColor = 3'd7;
      @(negedge clk); brush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_third_x", wx, 100);
      chk("rst_mid_third_we", we, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_we_low", we, 0);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_mid_ready", ready, 1);
      nw = 0;
      repeat (30) begin @(negedge clk); if (we) nw++; end
      chk("rst_mid_no_writes", nw, 0);

      s_brush = 1'b1; s_clear = 1'b1; cx = 10'd3; cy = 10'd3; radius = 2'd1; newColor = 3'd7;
      @(negedge clk);
      s_brush = 1'b0; s_clear = 1'b0;
      cnt = 0; bad = 0; ord = 0; ex = 0; ey = 0; lx = -1; ly = -1; sdone = 0;
      smid = s_ready;
      for (int i = 0; i < 400; i++) begin
         if (s_we) begin
            cnt++;
            if (s_wColor !== 3'b010) bad++;
            if (int'(s_wx) != ex || int'(s_wy) != ey) ord++;
            lx = int'(s_wx); ly = int'(s_wy);
            ex++;
            if (ex == 16) begin ex = 0; ey++; end
         end
         if (s_done) begin sdone = 1; break; end
         @(negedge clk);
      end
      chk("clear_busy", smid, 0);
      chk("clear_count", cnt, 192);
      chk("clear_colour", bad, 0);
      chk("clear_order", ord, 0);
      chk("clear_last_x", lx, 15);
      chk("clear_last_y", ly, 11);
      chk("clear_done", sdone, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
